ofm_drain: RTL and testbench
============================

Name: ofm_drain

Overview:
- Read-side controller for the 16-bit uGEMM-rate systolic array output path.
- After accumulation finishes, it drives the per-column en_o/clr_o shift-out controls and captures the column-skewed ofm words.
- It deskews them into complete result rows and hands one row at a time to the downstream buffer over a valid/ready handshake.
- Sits between the array's ofm outputs and the output SRAM writer.

Parameters:
- HEIGHT, 4, array rows (PE rows per column); number of result rows drained.
- WIDTH, 4, array columns; number of ofm words per result row.
- OWIDTH, 24, ofm word width.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle request to drain the array (issued after the last mac_done)
- busy  output  1  drain in progress
- done  output  1  one-cycle pulse when the final row is accepted
- en_o  output  WIDTH  per-column shift-out enable to the array
- clr_o  output  WIDTH  per-column accumulator clear to the array
- ofm  input  OWIDTH x WIDTH (unpacked [WIDTH-1:0])  column outputs of the array (row-0 PE register of each column)
- out_data  output  OWIDTH x WIDTH (unpacked [WIDTH-1:0])  deskewed result row
- out_row  output  max(1,$clog2(HEIGHT))  index of the row in out_data
- out_valid  output  1  out_data/out_row valid
- out_ready  input  1  downstream accepts row when out_valid && out_ready

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: all outputs 0; state IDLE; step counter t=0; deskew registers 0.
- Array contract: en_o[w] high at an edge shifts column w up one PE and inserts 0 at the bottom; ofm[w] shows the next row one cycle later.
- States:
  - IDLE -> DRAIN on start. busy rises the cycle after start is sampled.
  - DRAIN -> CLEAR after step t=HEIGHT+WIDTH-2 advances.
  - CLEAR lasts 1 cycle -> FLUSH.
  - FLUSH -> IDLE on the final handshake.
- start while busy is ignored.
- advance = !out_valid || out_ready. When advance=0: t, en_o and the deskew registers are frozen, and en_o=0.
- DRAIN, per column w on an advance cycle: if w <= t < w+HEIGHT, capture ofm[w] as row r=t-w and assert en_o[w] in the same cycle. Otherwise en_o[w]=0.
- Deskew: column w passes through WIDTH-1-w advance-gated delay stages. Column WIDTH-1 has 0 stages.
- Row r is complete at t=r+WIDTH-1. On that advance edge, out_data and out_row load and out_valid is set.
- out_valid clears on handshake unless a new row loads in the same cycle. A new row and a handshake may coincide, giving back-to-back rows.
- Latency without backpressure: start sampled at cycle 0 -> row r has out_valid in cycle r+WIDTH+1. The last row is in cycle HEIGHT+WIDTH.
- out_data, out_row and out_valid are stable while out_valid && !out_ready.
- done pulses in the cycle of the final row handshake (out_row=HEIGHT-1). busy falls in the same cycle; the state is IDLE the next cycle.
- A start arriving in the done cycle is ignored.
- Reset mid-operation: immediate return to reset values, with no clr_o pulse. A partially drained array is the issuer's responsibility.
- No arithmetic is performed; data passes bit-exact.

Optional Feature:
- OFM_DRAIN_CLR_EN defined: in state CLEAR, clr_o is all-ones for exactly 1 cycle, after the last en_o and independent of out_ready. This guarantees cleared accumulators before the next tile.
- Not defined: CLEAR is skipped (DRAIN -> FLUSH) and clr_o is constantly 0. The zero fill from shifting is relied on instead.

Test Plan:
- Column w preloaded with rows {16*r+w}, out_ready=1, start at cycle 0 -> rows 0..3 in cycles 5..8, out_data=[16r+0..16r+3], out_row=r; done in cycle 8.
- en_o trace (no stall) -> en_o[0] high cycles 1-4, en_o[1] 2-5, en_o[2] 3-6, en_o[3] 4-7; never two shifts per row per column.
- out_ready low for cycles 5-9 -> row 0 held unchanged, en_o=0 during the stall, no data loss; rows resume in order from cycle 10.
- start pulsed again at cycle 3 and in the done cycle -> ignored; busy/done timing identical to the first test.
- rst_n low at cycle 4 -> from cycle 5 all outputs 0, state IDLE; a new start drains the new preload correctly.
- With OFM_DRAIN_CLR_EN: clr_o=4'b1111 exactly in cycle 8 under no backpressure. Without it: clr_o stays 0 throughout.

Source files
------------

// File: rtl/ofm_drain.sv
// ofm_drain: read-side drain controller for the systolic array output path.
//
// Once accumulation is finished, a start pulse makes this block shift each
// array column up, one row per step. Column w begins w steps after column 0,
// so the words arrive skewed by column. Each column's capture passes through
// WIDTH-1-w delay stages to realign the skew. The block then hands complete
// result rows, one at a time, to the output SRAM writer over valid/ready.
//
// Optional build macro: OFM_DRAIN_CLR_EN
//   defined   : a CLEAR state pulses clr_o all-ones for one cycle after the
//               last shift.
//   undefined : CLEAR is never entered and clr_o stays 0. The zeros shifted
//               in from the bottom of the array leave it clear.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   start      one-cycle drain request (ignored while busy)
//   busy       drain in progress
//   done       pulse in the cycle the final row is accepted
//   en_o       per-column shift-out enable to the array
//   clr_o      per-column accumulator clear to the array
//   ofm        per-column array outputs (row-0 PE register)
//   out_data   deskewed result row
//   out_row    index of the row in out_data
//   out_valid  out_data/out_row valid
//   out_ready  downstream accepts the row when out_valid && out_ready
//
// state | meaning
// IDLE  | waiting for start
// DRAIN | stepping t through 0..HEIGHT+WIDTH-2, shifting and capturing
// CLEAR | one-cycle accumulator clear (OFM_DRAIN_CLR_EN builds only)
// FLUSH | waiting for the last row handshake
module ofm_drain #(
  parameter  int HEIGHT = 4,
  parameter  int WIDTH  = 4,
  parameter  int OWIDTH = 24,
  localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  en_o,
  output logic [WIDTH-1:0]  clr_o,
  input  logic [OWIDTH-1:0] ofm      [WIDTH-1:0],
  output logic [OWIDTH-1:0] out_data [WIDTH-1:0],
  output logic [RW-1:0]     out_row,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int TW     = $clog2(HEIGHT + WIDTH);
  localparam int T_LAST = HEIGHT + WIDTH - 2;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     t;
  logic              advance;
  logic              step;
  logic              last_hs;
  logic [OWIDTH-1:0] tap [WIDTH-1:0];

  // A held row blocks the whole pipeline. Every stage freezes together, so
  // no skewed word is lost while the downstream stalls.
  assign advance = !out_valid || out_ready;
  assign step    = (state == DRAIN) && advance;

  // The final row can be accepted in CLEAR as well as in FLUSH. Without
  // backpressure it becomes valid in the same cycle CLEAR runs.
  assign last_hs = ((state == CLEAR) || (state == FLUSH)) && out_valid && out_ready
                   && (out_row == RW'(HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= state_nxt;
      if (step) t <= (t == TW'(T_LAST)) ? '0 : t + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    en_o      = '0;
    clr_o     = '0;
    case (state)
      IDLE: if (start) state_nxt = DRAIN;
      DRAIN: begin
        for (int w = 0; w < WIDTH; w++)
          en_o[w] = advance && (int'(t) >= w) && (int'(t) < w + HEIGHT);
        if (advance && (t == TW'(T_LAST))) begin
`ifdef OFM_DRAIN_CLR_EN
          state_nxt = CLEAR;
`else
          state_nxt = FLUSH;
`endif
        end
      end
      CLEAR: begin
`ifdef OFM_DRAIN_CLR_EN
        clr_o = '1;
`endif
        state_nxt = FLUSH;
        if (last_hs) begin
          state_nxt = IDLE;
          done      = 1'b1;
          busy      = 1'b0;
        end
      end
      FLUSH: begin
        if (last_hs) begin
          state_nxt = IDLE;
          done      = 1'b1;
          busy      = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Deskew. The delay stages shift on every drain step, even outside a
  // column's capture window. Words taken outside the window never line up
  // with a row load, so they are harmless.
  for (genvar w = 0; w < WIDTH; w++) begin : g_col
    localparam int D = WIDTH - 1 - w;
    if (D == 0) begin : g_direct
      assign tap[w] = ofm[w];
    end else begin : g_dly
      logic [OWIDTH-1:0] sr [D];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else if (step) begin
          sr[0] <= ofm[w];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign tap[w] = sr[D-1];
    end
  end

  // Row r is complete once the last column has produced it, at t = r+WIDTH-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      for (int w = 0; w < WIDTH; w++) out_data[w] <= '0;
    end else if (step && (int'(t) >= WIDTH - 1)) begin
      out_valid <= 1'b1;
      out_row   <= RW'(int'(t) - (WIDTH - 1));
      out_data  <= tap;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofm_drain.sv
module tb_ofm_drain;
  localparam int H  = 4;
  localparam int W  = 4;
  localparam int OW = 24;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done, out_valid, out_ready;
  logic [W-1:0]  en_o, clr_o;
  logic [OW-1:0] ofm      [W-1:0];
  logic [OW-1:0] out_data [W-1:0];
  logic [1:0]    out_row;

  always #5 clk = ~clk;

  ofm_drain #(.HEIGHT(H), .WIDTH(W), .OWIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .en_o(en_o), .clr_o(clr_o), .ofm(ofm), .out_data(out_data),
    .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Array model: column w is a stack of H registers with row 0 on top.
  logic [OW-1:0] arr [W][H];
  logic [W-1:0]  en_q;
  logic          load_pre = 1'b0;
  int            pre_off  = 0;

  always @(negedge clk) en_q <= en_o;

  always @(posedge clk) begin
    for (int w = 0; w < W; w++)
      for (int r = 0; r < H; r++) begin
        if (load_pre) arr[w][r] <= OW'(pre_off + 16*r + w);
        else if (en_q[w] === 1'b1) begin
          if (r == H-1) arr[w][r] <= '0;
          else          arr[w][r] <= arr[w][r+1];
        end
      end
  end

  always_comb for (int w = 0; w < W; w++) ofm[w] = arr[w][0];

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  typedef struct {
    logic [W*OW-1:0] d;
    int              row;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Monitor: each accepted row is checked against the next expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_row @cycle %0d: actual row=%0d required=none", cyc, out_row);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_row", out_row, mon_e.row);
        chk("sb_cycle", cyc, mon_e.cyc);
        for (int w = 0; w < W; w++)
          chk($sformatf("sb_data[%0d]", w), out_data[w], mon_e.d[w*OW +: OW]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_en_o"}, en_o, 0);
    chk({pfx, "_clr_o"}, clr_o, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_row"}, out_row, 0);
    for (int w = 0; w < W; w++) chk($sformatf("%s_out_data[%0d]", pfx, w), out_data[w], 0);
  endtask

  // Expected en_o in cycle k after the start cycle. Without a stall, step
  // t = k-1. The 5..9 stall freezes t at 4 until cycle 10.
  function automatic logic [W-1:0] exp_en(input int k, input bit stall);
    logic [W-1:0] v;
    int tt;
    v = '0;
    if (k < 1) return v;
    if (stall && k >= 5 && k <= 9) return v;
    tt = (stall && k >= 10) ? k - 6 : k - 1;
    if (tt > H + W - 2) return v;
    for (int w = 0; w < W; w++) v[w] = (tt >= w) && (tt < w + H);
    return v;
  endfunction

  task automatic run(input int off, input bit stall, input bit extra, input bit rst_mid);
    int   c0, done_c, last_k;
    exp_t e;
    load_pre = 1'b1;
    pre_off  = off;
    tick();
    load_pre = 1'b0;
    c0     = cyc;
    done_c = stall ? 13 : 8;
    if (!rst_mid)
      for (int r = 0; r < H; r++) begin
        for (int w = 0; w < W; w++) e.d[w*OW +: OW] = OW'(off + 16*r + w);
        e.row = r;
        e.cyc = c0 + 5 + r + (stall ? 5 : 0);
        sb.push_back(e);
      end
    last_k = rst_mid ? 5 : done_c + 3;
    for (int k = 0; k <= last_k; k++) begin
      start     = (k == 0) || (extra && (k == 3 || k == done_c));
      out_ready = !(stall && k >= 5 && k <= 9);
      rst_n     = !(rst_mid && k == 4);
      @(negedge clk);
      if (rst_mid && k == 5) chk_zero("midreset");
      else if (!(rst_mid && k == 4)) begin
        chk($sformatf("busy_k%0d", k), busy, (k >= 1 && k < done_c));
        chk($sformatf("done_k%0d", k), done, (k == done_c));
`ifdef OFM_DRAIN_CLR_EN
        chk($sformatf("clr_o_k%0d", k), clr_o, (k == done_c) ? 4'hF : 4'h0);
`else
        chk($sformatf("clr_o_k%0d", k), clr_o, 0);
`endif
        chk($sformatf("en_o_k%0d", k), en_o, exp_en(k, stall));
        if (stall && k >= 5 && k <= 9) begin
          chk($sformatf("hold_valid_k%0d", k), out_valid, 1);
          chk($sformatf("hold_row_k%0d", k), out_row, 0);
          for (int w = 0; w < W; w++)
            chk($sformatf("hold_data%0d_k%0d", w, k), out_data[w], off + w);
        end
      end
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    tick();
    rst_n = 1'b1;
    run(0,   1'b0, 1'b0, 1'b0);
    run(256, 1'b1, 1'b0, 1'b0);
    run(512, 1'b0, 1'b1, 1'b0);
    run(768, 1'b0, 1'b0, 1'b1);
    run(1024, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
